// File: rtl/switch_in_arbiter.sv
// switch_in_arbiter
//
// Upstream stage of the switch-module delay line. Collects NUB independent
// valid/ready write-request ports into per-port single-entry holding registers,
// picks one held word per cycle by round-robin and presents it, registered and
// tagged with its source port index, to the downstream delay/alignment stage.
//
// Parameters:
//   WIDTH  data bits per port word
//   NUB    number of input ports (>= 2)
//   PTR_W  port-index width, must equal ceil(log2(NUB))
//
// Ports:
//   clk        system clock, all state on rising edge
//   rst        asynchronous, active-high reset
//   in_valid   per-port request valid (bit j = port j)
//   in_data    port j word at bits [(j+1)*WIDTH-1 : j*WIDTH]
//   in_ready   per-port accept; transfer when in_valid[j] & in_ready[j]
//   out_valid  registered output word valid
//   out_data   registered selected word
//   out_port   index of the port that supplied out_data
//   out_ready  downstream accept; fire = out_valid & out_ready
//
// Build option:
//   SWITCH_ARB_PORT0_PRIO_EN  when defined, port 0 has strict priority over the
//                             round-robin ports 1..NUB-1 and its grants leave the
//                             round-robin pointer untouched. Port list and timing
//                             are identical in both builds.

module switch_in_arbiter #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NUB   = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUB-1:0]       in_valid,
    input  logic [WIDTH*NUB-1:0] in_data,
    output logic [NUB-1:0]       in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [PTR_W-1:0]     out_port,
    input  logic                 out_ready
);

    // Pointer starts at the last port so that port 0 wins the first grant.
    localparam logic [PTR_W-1:0] RR_RESET = PTR_W'(NUB - 1);

    // Holding registers, one entry per port.
    logic [NUB-1:0]   hold_valid_q;
    logic [WIDTH-1:0] hold_data_q [NUB];

    // Arbitration state and output register.
    logic [PTR_W-1:0] rr_ptr_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [PTR_W-1:0] out_port_q;

    logic             any_hold;
    logic             load;
    logic [PTR_W-1:0] rr_grant;
    logic [PTR_W-1:0] grant;
    logic             rr_update;
    logic [NUB-1:0]   take;
    logic [NUB-1:0]   in_xfer;

    // (base + off) mod NUB for base < NUB and off <= NUB.
    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                  input int unsigned      off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NUB) begin
            sum = sum - NUB;
        end
        return PTR_W'(sum);
    endfunction

    assign any_hold = |hold_valid_q;

    // The output register accepts a new word when it is empty or draining this
    // cycle, and only if some port has a word waiting.
    assign load = (~out_valid_q | out_ready) & any_hold;

    // Round-robin search: first held port after rr_ptr, wrapping modulo NUB.
    always_comb begin
        logic             found;
        logic [PTR_W-1:0] idx;
        found    = 1'b0;
        rr_grant = '0;
        for (int unsigned k = 1; k <= NUB; k++) begin
            idx = wrap_idx(rr_ptr_q, k);
            if (!found && hold_valid_q[idx]) begin
                found    = 1'b1;
                rr_grant = idx;
            end
        end
    end

`ifdef SWITCH_ARB_PORT0_PRIO_EN
    // Port 0 bypasses the rotation entirely. When it is idle the round-robin
    // search above naturally lands on ports 1..NUB-1 only.
    always_comb begin
        if (hold_valid_q[0]) begin
            grant     = '0;
            rr_update = 1'b0;
        end else begin
            grant     = rr_grant;
            rr_update = 1'b1;
        end
    end
`else
    assign grant     = rr_grant;
    assign rr_update = 1'b1;
`endif

    always_comb begin
        take = '0;
        if (load) begin
            take[grant] = 1'b1;
        end
    end

    // A draining entry may be refilled in the same cycle; in_ready never looks
    // at in_valid so there is no combinational loop through upstream.
    assign in_ready = ~hold_valid_q | take;
    assign in_xfer  = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid_q <= '0;
            for (int j = 0; j < int'(NUB); j++) begin
                hold_data_q[j] <= '0;
            end
        end else begin
            for (int j = 0; j < int'(NUB); j++) begin
                // A new transfer wins over a take: the entry stays valid with
                // the fresh word.
                if (in_xfer[j]) begin
                    hold_valid_q[j] <= 1'b1;
                    hold_data_q[j]  <= in_data[j*WIDTH +: WIDTH];
                end else if (take[j]) begin
                    hold_valid_q[j] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_port_q  <= '0;
            rr_ptr_q    <= RR_RESET;
        end else if (load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= hold_data_q[grant];
            out_port_q  <= grant;
            if (rr_update) begin
                rr_ptr_q <= grant;
            end
        end else if (out_ready) begin
            // Drained with nothing to reload: data and tag keep their values.
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_port  = out_port_q;

endmodule

// File: tb/tb_switch_in_arbiter.sv
module tb_switch_in_arbiter;

    localparam int WIDTH = 16;
    localparam int NUB   = 4;
    localparam int PTR_W = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUB-1:0]       in_valid = '0;
    logic [WIDTH*NUB-1:0] in_data = '0;
    logic [NUB-1:0]       in_ready;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic [PTR_W-1:0]     out_port;
    logic                 out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [PTR_W-1:0] port;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t             exp_q[$];
    exp_t             mon_e;
    logic [WIDTH-1:0] src_q[NUB][$];
    logic [NUB-1:0]   acc;

    always #5 clk = ~clk;

    switch_in_arbiter #(
        .WIDTH(WIDTH),
        .NUB  (NUB),
        .PTR_W(PTR_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_port (out_port),
        .out_ready(out_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    // Upstream sources: each port presents the head of its queue and pops it
    // once a handshake completes on the rising edge.
    always begin
        @(negedge clk);
        acc = in_valid & in_ready & {NUB{~rst}};
        @(posedge clk);
        #1;
        for (int j = 0; j < NUB; j++) begin
            if (acc[j]) void'(src_q[j].pop_front());
            in_valid[j] = (src_q[j].size() != 0);
            in_data[j*WIDTH +: WIDTH] = (src_q[j].size() != 0) ? src_q[j][0] : '0;
        end
    end

    // Scoreboard: every downstream fire must match the next expected word.
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL out_unexpected: got port %0d data %0h, expected no output",
                       out_port, out_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_port", {30'd0, out_port}, {30'd0, mon_e.port});
                check("out_data", {16'd0, out_data}, {16'd0, mon_e.data});
            end
        end
    end

    task automatic push(input int port, input logic [WIDTH-1:0] data);
        src_q[port].push_back(data);
    endtask

    task automatic expect_out(input int port, input logic [WIDTH-1:0] data);
        exp_t e;
        e.port = PTR_W'(port);
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Counts falling edges until out_valid rises (bounded).
    task automatic wait_out_valid(input int max, output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        check("out_valid_seen", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic drain(input int max);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max) begin
            @(negedge clk);
            n++;
        end
        check("drain_remaining", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n;

        // Power-on reset state.
        repeat (2) @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {16'd0, out_data}, 32'd0);
        check("rst_out_port", {30'd0, out_port}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rdy_after_rst", {28'd0, in_ready}, 32'hF);

        // Reset mid-stream: output stalled on port 0, holds = 1011.
        push(0, 16'h1110);
        push(0, 16'h1111);
        push(1, 16'h1121);
        push(3, 16'h1131);
        wait_out_valid(20, n);
        check("stall_port", {30'd0, out_port}, 32'd0);
        check("stall_data", {16'd0, out_data}, 32'h1110);
        check("stall_in_ready", {28'd0, in_ready}, 32'h4);
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_out_data", {16'd0, out_data}, 32'd0);
        check("midrst_out_port", {30'd0, out_port}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", {28'd0, in_ready}, 32'hF);

        // Single port streaming back-to-back.
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        for (int i = 1; i <= 8; i++) begin
            push(2, 16'(i));
            expect_out(2, 16'(i));
        end
        wait_out_valid(20, n);
        check("single_latency", n, 3);
        for (int i = 0; i < 8; i++) begin
            check("single_no_bubble", {31'd0, out_valid}, 32'd1);
            @(negedge clk);
        end
        check("single_drain_valid", {31'd0, out_valid}, 32'd0);
        check("single_drain_data", {16'd0, out_data}, 32'h8);
        check("single_drain_port", {30'd0, out_port}, 32'd2);
        drain(20);

        // Fairness: all ports requesting continuously.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < NUB; j++) begin
                push(j, 16'hA000 + 16'(r * 16 + j));
            end
        end
        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < NUB; j++) begin
                expect_out(j, 16'hA000 + 16'(r * 16 + j));
            end
        end
        wait_out_valid(20, n);
        for (int i = 0; i < 8; i++) begin
            check("fair_no_bubble", {31'd0, out_valid}, 32'd1);
            @(negedge clk);
        end
        drain(20);

        // Backpressure with all ports loaded.
        do_reset();
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < NUB; j++) begin
                push(j, 16'hB000 + 16'(r * 16 + j));
                expect_out(j, 16'hB000 + 16'(r * 16 + j));
            end
        end
        wait_out_valid(20, n);
        for (int i = 0; i < 5; i++) begin
            check("bp_frozen_valid", {31'd0, out_valid}, 32'd1);
            check("bp_frozen_port", {30'd0, out_port}, 32'd0);
            check("bp_frozen_data", {16'd0, out_data}, 32'hB000);
            check("bp_in_ready", {28'd0, in_ready}, 32'h0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            check("bp_resume_no_bubble", {31'd0, out_valid}, 32'd1);
            @(negedge clk);
        end
        drain(20);

        // Wrap-around and refill in the take cycle.
        do_reset();
        push(0, 16'hC000);
        push(0, 16'hC001);
        push(3, 16'hC003);
        expect_out(0, 16'hC000);
        expect_out(3, 16'hC003);
        expect_out(0, 16'hC001);
        drain(30);

        // Port 0 busy alongside ports 1 and 2.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push(0, 16'hD000 + 16'(i * 16));
        end
        push(1, 16'hD100);
        push(2, 16'hD200);
`ifdef SWITCH_ARB_PORT0_PRIO_EN
        for (int i = 0; i < 4; i++) begin
            expect_out(0, 16'hD000 + 16'(i * 16));
        end
        expect_out(1, 16'hD100);
        expect_out(2, 16'hD200);
`else
        expect_out(0, 16'hD000);
        expect_out(1, 16'hD100);
        expect_out(2, 16'hD200);
        for (int i = 1; i < 4; i++) begin
            expect_out(0, 16'hD000 + 16'(i * 16));
        end
`endif
        drain(30);

        repeat (3) @(negedge clk);
        check("end_out_valid", {31'd0, out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/switch_in_arbiter.md
Name: switch_in_arbiter

Overview:
- Upstream stage of the switch-module delay line.
- Collects NUB independent write-request ports, each with a valid/ready handshake, into per-port single-entry holding registers.
- Selects one held word per cycle by round-robin and presents it, registered, with its source port index, to the downstream delay/alignment stage.
- Output is a single registered valid/ready stream: WIDTH data bits plus a PTR_W-bit port tag.

Parameters:
WIDTH, 16, data bits per port word
NUB, 4, number of input ports (>=2)
PTR_W, 2, port-index width; PTR_W = ceil(log2(NUB)), and the instantiating module must set it consistently

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  NUB  per-port request valid; bit j belongs to port j
in_data  input  WIDTH*NUB  port j word at bits [(j+1)*WIDTH-1 : j*WIDTH]
in_ready  output  NUB  per-port accept; a transfer occurs when in_valid[j] & in_ready[j]
out_valid  output  1  registered output word valid
out_data  output  WIDTH  registered selected word
out_port  output  PTR_W  index of the port that supplied out_data
out_ready  input  1  downstream accept; fire = out_valid & out_ready

Behaviour:
- Reset (asynchronous, active-high): clears all state.
  - hold_valid[*]=0, out_valid=0, out_data=0, out_port=0.
  - Round-robin pointer rr_ptr = NUB-1, so port 0 wins first.
  - in_ready comes up all-ones in the first cycle after rst deasserts.
- Holding registers: one word per port, hold_data[j] and hold_valid[j].
  - in_ready[j] = ~hold_valid[j] | take[j], where take[j] means the hold entry moves to the output register this cycle.
  - This allows a full-throughput refill in the same cycle the entry drains.
  - in_ready is combinational from state and out_ready only; it never depends on in_valid.
- Output register load condition: load = (~out_valid | out_ready) & (|hold_valid).
- Arbitration on load:
  - grant = first j with hold_valid[j], searching rr_ptr+1, rr_ptr+2, ... modulo NUB (wrap-around).
  - take = one-hot(grant).
  - On the edge: out_data <= hold_data[grant], out_port <= grant, out_valid <= 1, rr_ptr <= grant.
- Drain without reload: on fire with no hold_valid set, out_valid <= 0 and out_data/out_port hold their last values.
- Stall: out_valid=1 & out_ready=0 leaves out_valid, out_data, out_port and rr_ptr unchanged, and no take occurs.
- Latency: a word accepted at edge N appears on out_* after edge N+1 at the earliest.
  - Throughput is one word per cycle aggregate.
  - A single port streaming alone achieves one word per cycle.
- Fairness: with all ports continuously requesting, the grant order is 0,1,...,NUB-1,0,...
  - No port waits more than NUB-1 grants.
- Simultaneous events: take[j] and a new transfer on port j in the same cycle leaves hold_valid[j]=1 with the new word.
- Reset mid-operation: held and output words are discarded with no flush.
  - Upstream must re-send any word not yet accepted downstream.
- Handshake rules:
  - in_data[j] must be stable while in_valid[j]=1 & in_ready[j]=0 (upstream obligation; an assertion is allowed).
  - out_data and out_port are stable while out_valid=1 & out_ready=0.

Optional Feature:
- Macro: SWITCH_ARB_PORT0_PRIO_EN
- Defined: port 0 has strict priority.
  - If hold_valid[0] at load, grant=0 regardless of rr_ptr, and rr_ptr is not updated.
  - Otherwise arbitration is round-robin among ports 1..NUB-1 as specified.
- Undefined: pure round-robin across all NUB ports. Port list and timing are identical in both builds.

Test Plan:
- Reset: assert rst mid-stream with out_valid=1 and hold_valid=4'b1011 -> immediately out_valid=0, out_data=0, out_port=0, in_ready=4'b1111 after release.
- Single port: port 2 streams 0x0001..0x0008 back-to-back, out_ready=1 -> out_data 0x0001..0x0008 on consecutive cycles, out_port=2, first word one cycle after acceptance.
- Fairness: all four ports held valid with data 0xA000+j, out_ready=1 -> out_port sequence 0,1,2,3,0,1,2,3 with no bubbles.
- Backpressure: out_ready=0 for 5 cycles with all ports loaded -> out_* frozen, in_ready=4'b0000, rr_ptr unchanged; on release, order resumes from the next port after the frozen one.
- Wrap and simultaneity: rr_ptr=3, ports 0 and 3 valid -> grant 0; then port 0 refills in the take cycle -> next grant 3, then 0 again, with no lost word.
- SWITCH_ARB_PORT0_PRIO_EN defined: port 0 valid every cycle plus ports 1 and 2 valid -> port 0 granted every load, and ports 1 and 2 are not granted until port 0 idles, then 1 before 2.
